// File: rtl/mac_out_collector_pkg.sv
// Shared defaults for the MAC array output collector, kept in one place so
// they match the array instance.
package mac_out_collector_pkg;

   localparam int COL_DEF     = 8;
   localparam int PSUM_BW_DEF = 16;
   localparam int DEPTH_DEF   = 64;

   // One extra pointer bit distinguishes a full FIFO from an empty one.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/mac_out_collector_col_fifo.sv
// One column's result buffer: storage plus its own write pointer. The read
// pointer is shared and owned by the top level.
module mac_out_collector_col_fifo
   import mac_out_collector_pkg::*;
#(
   parameter int psum_bw = PSUM_BW_DEF,
   parameter int depth   = DEPTH_DEF,
   parameter int ptr_bw  = ptr_width(depth)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ptr_bw-1:0]  i_rptr,
   input  logic [psum_bw-1:0] i_din,
   input  logic               i_wr,
   output logic [psum_bw-1:0] o_head,
   output logic               o_empty,
   output logic               o_full
);

   localparam int aw = $clog2(depth);

   logic [psum_bw-1:0] r_mem [depth];
   logic [ptr_bw-1:0]  r_wptr;
   logic [ptr_bw-1:0]  w_count;
   logic               w_push;

   // Modular difference of the pointers is the occupancy, wrap included.
   assign w_count = r_wptr - i_rptr;
   assign o_full  = (w_count == ptr_bw'(depth));
   assign o_empty = (w_count == '0);
   assign w_push  = i_wr & ~o_full;
   assign o_head  = r_mem[i_rptr[aw-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr <= '0;
      end else if (w_push) begin
         r_wptr <= r_wptr + ptr_bw'(1);
      end
   end

   // Storage is deliberately not reset; contents are invisible until written.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr[aw-1:0]] <= i_din;
      end
   end

endmodule

// File: rtl/mac_out_collector.sv
// De-skews the per-column partial sums leaving the systolic array's south
// edge and presents them as row-aligned vectors through an FWFT read port.
module mac_out_collector
   import mac_out_collector_pkg::*;
#(
   parameter int col     = COL_DEF,
   parameter int psum_bw = PSUM_BW_DEF,
   parameter int depth   = DEPTH_DEF,
   parameter int ptr_bw  = ptr_width(depth)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [psum_bw*col-1:0] in,
   input  logic [col-1:0]         wr,
   input  logic                   rd,
   output logic [psum_bw*col-1:0] out,
   output logic                   o_valid,
   output logic                   o_full,
   output logic                   o_overflow,
   output logic                   o_underflow
);

   // Handshake: wr[c] is a write strobe with no back-pressure (a write into a
   // full column is dropped and flagged); o_valid/rd form the read side, where
   // a row pops only on an edge with rd=1 and o_valid=1, otherwise rd flags
   // underflow.
   logic [ptr_bw-1:0] r_rptr;
   logic [col-1:0]    w_empty;
   logic [col-1:0]    w_full;
   logic              w_pop;
   logic              r_overflow;
   logic              r_underflow;

   generate
      for (genvar g = 0; g < col; g++) begin : g_col
         mac_out_collector_col_fifo #(
            .psum_bw (psum_bw),
            .depth   (depth),
            .ptr_bw  (ptr_bw)
         ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .i_rptr  (r_rptr),
            .i_din   (in[psum_bw*g +: psum_bw]),
            .i_wr    (wr[g]),
            .o_head  (out[psum_bw*g +: psum_bw]),
            .o_empty (w_empty[g]),
            .o_full  (w_full[g])
         );
      end
   endgenerate

   assign o_valid     = ~|w_empty;
   assign o_full      = |w_full;
   assign w_pop       = rd & o_valid;
   assign o_overflow  = r_overflow;
   assign o_underflow = r_underflow;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rptr      <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_pop) begin
            r_rptr <= r_rptr + ptr_bw'(1);
         end
         if (rd & ~o_valid) begin
            r_underflow <= 1'b1;
         end
         // Full check uses pre-edge occupancy, so a same-cycle pop never rescues a write.
         if (|(wr & w_full)) begin
            r_overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mac_out_collector.sv
// Directed and randomized checks of the output collector against a queue
// model of per-column buffers.
module tb_mac_out_collector;

   localparam int COL   = 8;
   localparam int PW    = 16;
   localparam int DEPTH = 64;
   localparam int NROWS = 193;

   logic                clk;
   logic                reset;
   logic [PW*COL-1:0]   in;
   logic [COL-1:0]      wr;
   logic                rd;
   logic [PW*COL-1:0]   out;
   logic                o_valid;
   logic                o_full;
   logic                o_overflow;
   logic                o_underflow;

   int checks;
   int errors;

   logic [PW-1:0]     mq [COL][$];
   logic              m_ovf;
   logic              m_udf;
   logic              popped;
   logic [PW*COL-1:0] last_pop;

   mac_out_collector dut (
      .clk         (clk),
      .reset       (reset),
      .in          (in),
      .wr          (wr),
      .rd          (rd),
      .out         (out),
      .o_valid     (o_valid),
      .o_full      (o_full),
      .o_overflow  (o_overflow),
      .o_underflow (o_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [PW*COL-1:0] obs, input logic [PW*COL-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic m_valid();
      for (int c = 0; c < COL; c++) if (mq[c].size() == 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic m_full();
      for (int c = 0; c < COL; c++) if (mq[c].size() == DEPTH) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check_all();
      logic [PW*COL-1:0] v;
      v = '0;
      chk("valid", {127'b0, o_valid}, {127'b0, m_valid()});
      chk("full", {127'b0, o_full}, {127'b0, m_full()});
      chk("overflow", {127'b0, o_overflow}, {127'b0, m_ovf});
      chk("underflow", {127'b0, o_underflow}, {127'b0, m_udf});
      if (m_valid()) begin
         for (int c = 0; c < COL; c++) v[c*PW +: PW] = mq[c][0];
         chk("head_row", out, v);
      end
   endtask

   // Apply one clock edge with the given inputs and advance the model.
   task automatic step(input logic [COL-1:0] w, input logic [PW*COL-1:0] d, input logic r);
      int   pre_size [COL];
      logic pre_valid;
      wr = w; in = d; rd = r;
      @(posedge clk);
      pre_valid = m_valid();
      for (int c = 0; c < COL; c++) pre_size[c] = mq[c].size();
      popped = 1'b0;
      if (r) begin
         if (pre_valid) begin
            popped = 1'b1;
            for (int c = 0; c < COL; c++) begin
               last_pop[c*PW +: PW] = mq[c][0];
               void'(mq[c].pop_front());
            end
         end else begin
            m_udf = 1'b1;
         end
      end
      for (int c = 0; c < COL; c++) begin
         if (w[c]) begin
            if (pre_size[c] < DEPTH) mq[c].push_back(d[c*PW +: PW]);
            else m_ovf = 1'b1;
         end
      end
      #1;
      wr = '0; rd = 1'b0;
      check_all();
   endtask

   task automatic do_reset();
      reset = 1'b1; wr = '0; rd = 1'b0;
      @(posedge clk);
      for (int c = 0; c < COL; c++) mq[c].delete();
      m_ovf = 1'b0; m_udf = 1'b0;
      #1;
      reset = 1'b0;
      check_all();
   endtask

   function automatic logic [PW*COL-1:0] fill_row(input logic [PW-1:0] base, input logic add_idx);
      logic [PW*COL-1:0] v;
      for (int c = 0; c < COL; c++) v[c*PW +: PW] = add_idx ? base + PW'(c) : base;
      return v;
   endfunction

   function automatic logic [PW*COL-1:0] seq_row(input int r);
      logic [PW*COL-1:0] v;
      for (int c = 0; c < COL; c++) v[c*PW +: PW] = PW'(r * 16 + c);
      return v;
   endfunction

   function automatic logic [PW*COL-1:0] rand_row();
      logic [PW*COL-1:0] v;
      for (int c = 0; c < COL; c++) v[c*PW +: PW] = PW'($urandom);
      return v;
   endfunction

   initial begin
      logic [PW*COL-1:0] d;
      logic [PW*COL-1:0] skew_exp;
      logic [COL-1:0]    w;
      int                next_row;
      checks = 0; errors = 0;
      reset = 1'b1; wr = '0; rd = 1'b0; in = '0;
      m_ovf = 1'b0; m_udf = 1'b0; popped = 1'b0; last_pop = '0;
      repeat (2) @(posedge clk);

      // Reset state
      do_reset();
      chk("rst_valid", {127'b0, o_valid}, '0);
      chk("rst_full", {127'b0, o_full}, '0);
      chk("rst_ovf", {127'b0, o_overflow}, '0);
      chk("rst_udf", {127'b0, o_underflow}, '0);

      // Skew fill
      for (int c = 0; c < COL; c++) begin
         d = '0;
         d[c*PW +: PW] = 16'h0100 + PW'(c);
         step(COL'(1) << c, d, 1'b0);
         chk("skew_valid", {127'b0, o_valid}, (c == COL - 1) ? 128'd1 : 128'd0);
      end
      skew_exp = fill_row(16'h0100, 1'b1);
      chk("skew_out", out, skew_exp);

      // Full / overflow on column 0
      do_reset();
      for (int i = 0; i < DEPTH; i++) step(8'h01, rand_row(), 1'b0);
      chk("full_set", {127'b0, o_full}, 128'd1);
      chk("no_ovf_yet", {127'b0, o_overflow}, '0);
      d = '0; d[PW-1:0] = 16'hDEAD;
      step(8'h01, d, 1'b0);
      chk("ovf_set", {127'b0, o_overflow}, 128'd1);
      chk("still_full", {127'b0, o_full}, 128'd1);
      step(8'hFE, fill_row(16'h0055, 1'b0), 1'b0);
      chk("no_dead", {127'b0, (out[PW-1:0] == 16'hDEAD)}, '0);

      // Underflow
      do_reset();
      step('0, '0, 1'b1);
      chk("udf_set", {127'b0, o_underflow}, 128'd1);
      chk("udf_valid", {127'b0, o_valid}, '0);
      step(8'hFF, fill_row(16'h0A00, 1'b1), 1'b0);
      chk("udf_row_valid", {127'b0, o_valid}, 128'd1);
      chk("udf_row", out, fill_row(16'h0A00, 1'b1));

      // Concurrent read / write
      do_reset();
      step(8'hFF, fill_row(16'd1, 1'b0), 1'b0);
      chk("cc_before", out, fill_row(16'd1, 1'b0));
      step(8'hFF, fill_row(16'd2, 1'b0), 1'b1);
      chk("cc_valid", {127'b0, o_valid}, 128'd1);
      chk("cc_after", out, fill_row(16'd2, 1'b0));

      // Reset mid-stream with overflow pending
      do_reset();
      for (int i = 0; i < 10; i++) step(8'hFF, rand_row(), 1'b0);
      for (int i = 0; i < DEPTH - 10; i++) step(8'h01, rand_row(), 1'b0);
      step(8'h01, rand_row(), 1'b0);
      chk("mid_ovf", {127'b0, o_overflow}, 128'd1);
      do_reset();
      chk("mid_valid", {127'b0, o_valid}, '0);
      chk("mid_full", {127'b0, o_full}, '0);
      chk("mid_ovf_clr", {127'b0, o_overflow}, '0);
      chk("mid_udf_clr", {127'b0, o_underflow}, '0);
      step(8'hFF, fill_row(16'h0C00, 1'b1), 1'b0);
      chk("mid_fresh", out, fill_row(16'h0C00, 1'b1));

      // Wrap-around: skewed sequential writes with back-to-back reads
      do_reset();
      next_row = 0;
      for (int t = 0; t < 210; t++) begin
         w = '0; d = '0;
         for (int c = 0; c < COL; c++) begin
            if (t - c >= 0 && t - c < NROWS) begin
               w[c] = 1'b1;
               d[c*PW +: PW] = PW'((t - c) * 16 + c);
            end
         end
         step(w, d, 1'b1);
         if (popped) begin
            chk("wrap_order", last_pop, seq_row(next_row));
            next_row++;
         end
      end
      chk("wrap_count", 128'(next_row), 128'(NROWS));

      // Random traffic: write-heavy then read-heavy to visit full and empty
      do_reset();
      for (int t = 0; t < 600; t++) begin
         if (t < 300) begin
            w = COL'($urandom) | COL'($urandom);
            step(w, rand_row(), ($urandom_range(0, 3) == 0));
         end else begin
            w = COL'($urandom) & COL'($urandom) & COL'($urandom);
            step(w, rand_row(), ($urandom_range(0, 3) != 0));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
